// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states and bus owner.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    YIELD
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    CPU,
    DMA
  } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the CPU MEM stage and a DMA burst port.
// CPU wins outside bursts; a DMA burst owns the memory except for one CPU beat
// after the CPU has been blocked CPU_WAIT_MAX cycles. Reads return one cycle later.
//
// state | meaning
// IDLE  | no burst open, CPU has priority, DMA gets leftover cycles
// BURST | DMA burst open, only DMA beats accepted
// YIELD | one-cycle window granting a blocked CPU a single beat
module dmem_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int CPU_WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_sb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_sb,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_we,
  output logic        mem_sb,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  import dmem_arb_pkg::*;

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(CPU_WAIT_MAX + 1);
  localparam logic [BW-1:0] BEAT_LIM = BW'(MAX_BURST);
  localparam logic [WW-1:0] WAIT_LIM = WW'(CPU_WAIT_MAX);

  arb_state_t    state;
  logic [BW-1:0] beat_cnt;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_inc;
  logic [WW-1:0] wait_inc;
  logic          burst_end;
  owner_t        owner;

  // saturating increments; the limits are reached before either could wrap
  assign beat_inc  = (beat_cnt == BEAT_LIM) ? beat_cnt : beat_cnt + 1'b1;
  assign wait_inc  = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + 1'b1;
  assign burst_end = dma_gnt & (dma_last | (beat_inc == BEAT_LIM));

  // combinational grants from the current state
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    case (state)
      IDLE: begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req & ~cpu_req;
      end
      BURST:   dma_gnt = dma_req;
      YIELD:   cpu_gnt = cpu_req;
      default: ;
    endcase
  end

  // pick the bus owner from the grants
  always_comb begin
    if (cpu_gnt)      owner = CPU;
    else if (dma_gnt) owner = DMA;
    else              owner = NONE;
  end

  // drive dmem from the owner; an idle bus is held at zero
  always_comb begin
    mem_we = 1'b0;
    mem_sb = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    case (owner)
      CPU: begin
        mem_we = cpu_we;
        mem_sb = cpu_sb;
        mem_a  = cpu_addr;
        mem_wd = cpu_wdata;
      end
      DMA: begin
        mem_we = dma_we;
        mem_sb = dma_sb;
        mem_a  = dma_addr;
        mem_wd = dma_wdata;
      end
      default: ;
    endcase
  end

  // FSM with beat and CPU-wait counters; an ending beat takes precedence over yielding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (dma_gnt && !dma_last) begin
            state    <= BURST;
            beat_cnt <= BW'(1);
          end else begin
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (burst_end) begin
            state    <= IDLE;
            beat_cnt <= '0;
            wait_cnt <= '0;
          end else begin
            if (dma_gnt) beat_cnt <= beat_inc;
            if (cpu_req) begin
              wait_cnt <= wait_inc;
              if (wait_inc == WAIT_LIM) state <= YIELD;
            end else begin
              wait_cnt <= '0;
            end
          end
        end
        YIELD: begin
          state    <= BURST;
          wait_cnt <= '0;
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // read responses: capture mem_rd on a granted read, valid for one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dma_rvalid <= dma_gnt & ~dma_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rd;
      if (dma_gnt && !dma_we) dma_rdata <= mem_rd;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory `dmem` between two requesters: the pipeline MEM stage (CPU port) and a DMA/loader port that moves word bursts. Sits between those requesters and `dmem`. It drives `dmem`'s `we`/`sb`/`a`/`wd` from the granted requester and returns read data with a fixed one-cycle registered latency. The CPU has priority outside bursts. A DMA burst holds the memory until it ends, except for bounded CPU preemption.

## Interface
Parameters:
- `MAX_BURST`, 8: max DMA beats per burst before forced release (≥2)
- `CPU_WAIT_MAX`, 4: cycles a requesting CPU may be blocked by a burst before it is granted one beat (≥1)

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock
- `reset` in 1: async active-high reset
- `cpu_req` in 1: CPU access request
- `cpu_we` in 1: CPU write
- `cpu_sb` in 1: CPU store byte (`wd[7:0]` only)
- `cpu_addr` in 32: CPU byte address
- `cpu_wdata` in 32: CPU write data
- `cpu_gnt` out 1: CPU beat accepted this cycle (combinational)
- `cpu_rvalid` out 1: CPU read data valid
- `cpu_rdata` out 32: CPU read data
- `dma_req`, `dma_we`, `dma_sb`, `dma_addr`[32], `dma_wdata`[32]: DMA equivalents of the CPU request inputs
- `dma_last` in 1: current DMA beat is the last of its burst
- `dma_gnt` out 1: DMA beat accepted this cycle
- `dma_rvalid` out 1, `dma_rdata` out 32: DMA read response
- `mem_we`, `mem_sb` out 1; `mem_a`, `mem_wd` out 32: to `dmem`
- `mem_rd` in 32: from `dmem` (combinational read)

## Operation
- Beat = cycle with `req & gnt` on a port. At most one grant per cycle. The memory bus is driven combinationally from the granted port. With no grant, `mem_we`, `mem_sb`, `mem_a` and `mem_wd` are all 0.
- `mem_a` carries the full byte address; word alignment is `dmem`'s job.
- States: IDLE, BURST, YIELD.
- **IDLE**
  - `cpu_req` → CPU granted.
  - Otherwise `dma_req` → DMA granted. If `dma_last=0` on that beat → BURST, with beat count 1.
- **BURST**
  - `dma_gnt = dma_req`; `cpu_gnt = 0`. Gaps (`dma_req=0`) keep the burst open.
  - Each DMA beat increments the beat count.
  - A beat with `dma_last=1`, or the beat that makes the count equal `MAX_BURST`, returns the state to IDLE. This is a forced truncation; the DMA re-requests to continue.
  - The wait counter increments each BURST cycle with `cpu_req=1`. When it reaches `CPU_WAIT_MAX` (and the current cycle does not end the burst) → YIELD.
- **YIELD**
  - `cpu_gnt = cpu_req`; `dma_gnt = 0`.
  - Always → BURST next cycle, with the wait counter cleared and the beat count kept.
- Wait counter clears on entry to BURST from IDLE, and whenever `cpu_req=0` in BURST.
- Counter widths are `$clog2(MAX_BURST+1)` and `$clog2(CPU_WAIT_MAX+1)`. Counters saturate and never wrap.
- Read beat (`we=0`): `mem_rd` is registered into that port's `rdata` at the closing edge. `rvalid` is high for exactly the next cycle.
- Write beats never raise `rvalid`. `rdata` holds its last value when `rvalid=0`.
- Requesters may change or withdraw a request at any time; only granted beats have effect.

## Timing
- Reset values: state IDLE, both counters 0, `cpu_rvalid=dma_rvalid=0`, `cpu_rdata=dma_rdata=0`.
- Grant is combinational, with no added latency. A write completes at the edge ending its grant cycle.
- Read latency: data and `rvalid` appear 1 cycle after the grant cycle. Back-to-back reads give back-to-back `rvalid`.
- Both requesting in IDLE → CPU wins; DMA is granted in the first cycle CPU does not request.
- `dma_last=1` on the `MAX_BURST`-th beat → single return to IDLE.
- Wait limit reached on the same cycle as the ending beat → IDLE, not YIELD.
- Reset asserted mid-burst or in YIELD → immediate (async) IDLE. Counters cleared, pending `rvalid` dropped.

## Structure
- Package `dmem_arb_pkg`: `arb_state_t` enum (IDLE, BURST, YIELD) and `owner_t` enum (NONE, CPU, DMA).
- Single module, no sub-module. One FSM, two counters, two response registers and a bus mux.

## Test plan
- Reset then CPU read at 0x8, with `mem_rd=0xDEADBEEF` → `cpu_gnt=1` in the same cycle; next cycle `cpu_rvalid=1`, `cpu_rdata=0xDEADBEEF`; `dma_rvalid=0`.
- Both request in IDLE; DMA single write (`dma_last=1`) of 0x12345678 to 0x4 → CPU granted first; DMA granted next cycle with `mem_we=1`, `mem_a=0x4`, `mem_wd=0x12345678`.
- DMA 4-beat read burst, CPU requesting from beat 2 with `CPU_WAIT_MAX=4` → DMA gets beats 1–4 uninterrupted (the limit is never reached); CPU is granted the cycle after `dma_last`.
- DMA burst with `dma_last` held 0 and CPU requesting continuously → after 4 blocked cycles, one YIELD cycle with a CPU beat, then DMA resumes. Forced IDLE after 8 total DMA beats.
- DMA `sb=1` write of 0xAB to 0x10 → `mem_sb=1`, `mem_wd=0x000000AB`, no `rvalid` on either port.
- Reset asserted mid-burst (beat 3) → outputs go to reset values with no clock edge needed; after release, a CPU request is granted immediately.
